inst_sequencer: RTL

- Master-side generator for the 36-bit instruction word consumed by the systolic core; replaces the bench-driven instruction stream.
- On `start`, runs one complete weight-stationary tile in order: weight fetch to L0, weight load into the array, activation fetch to L0, execute, output drain.
- Sits between the host/top controller and the core's `inst`/`ofifo_valid` pins.

---
 rtl/inst_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/inst_sequencer.sv
// inst_sequencer: builds the 36-bit instruction word for the systolic core and
// steps through one weight-stationary tile per start request:
// weight fetch to L0, weight load, activation fetch to L0, execute, output drain.
// Optional feature macro: INST_SEQ_TIMEOUT_EN (output-drain watchdog).
//
// state    | meaning
// IDLE     | waiting for start, IDLE word on inst
// WL0      | pmem read of col weight words into L0 (col+1 cycles)
// WLOAD    | L0 -> array weight load (col cycles)
// WDRAIN   | wait for the weight wavefront to settle (DRAIN_CYC cycles)
// AL0      | xmem read of a_len activation words into L0 (a_len+1 cycles)
// EXEC     | L0 -> array execute (a_len cycles)
// XDRAIN   | wait for the execute wavefront to settle (DRAIN_CYC cycles)
// OUT      | pop a_len results from the core output FIFO
// DONE     | one-cycle completion pulse
module inst_sequencer #(
  parameter int row       = 8,
  parameter int col       = 8,
  parameter int L0_DEPTH  = 64,
  parameter int DRAIN_CYC = row + col,
  parameter int TIMEOUT   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] w_base,
  input  logic [10:0] a_base,
  input  logic [10:0] a_len,
  input  logic        acc_en,
  input  logic        ofifo_valid,
  output logic [35:0] inst,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef INST_SEQ_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam int CW = 16;
  localparam int TW = $clog2(TIMEOUT + 1);
  // CEN/WEN are active-low, so the quiet word keeps those four bits high.
  localparam logic [35:0] IDLE_WORD = (36'd1 << 32) | (36'd1 << 31) | (36'd1 << 19) | (36'd1 << 18);

  typedef enum logic [3:0] {
    S_IDLE, S_WL0, S_WLOAD, S_WDRAIN, S_AL0, S_EXEC, S_XDRAIN, S_OUT, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [10:0]   wb_q, wb_d, ab_q, ab_d, len_q, len_d;
  logic [35:0]   inst_q, inst_d;
  logic          busy_q, done_q, err_q, err_d;
  logic          len_ok;

  assign len_ok = (a_len != 11'd0) && (a_len <= 11'(L0_DEPTH));

  // Next state, phase counter and the registered instruction word for that next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idle_d  = idle_q;
    wb_d    = wb_q;
    ab_d    = ab_q;
    len_d   = len_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (len_ok) begin
            state_d = S_WL0;
            wb_d    = w_base;
            ab_d    = a_base;
            len_d   = a_len;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WL0:    if (cnt_q == CW'(col))                  state_d = S_WLOAD;
      S_WLOAD:  if (cnt_q == CW'(col - 1))              state_d = S_WDRAIN;
      S_WDRAIN: if (cnt_q == CW'(DRAIN_CYC - 1))        state_d = S_AL0;
      S_AL0:    if (cnt_q == CW'(len_q))                state_d = S_EXEC;
      S_EXEC:   if (cnt_q == CW'(len_q) - CW'(1))       state_d = S_XDRAIN;
      S_XDRAIN: if (cnt_q == CW'(DRAIN_CYC - 1))        state_d = S_OUT;
      S_OUT: begin
        cnt_d = cnt_q + CW'(ofifo_valid);
        if (ofifo_valid)                  idle_d = '0;
        else if (idle_q != TW'(TIMEOUT))  idle_d = idle_q + TW'(1);
        // After a watchdog err the extra OUT cycle moves on to DONE.
        if (TimeoutEn && idle_q == TW'(TIMEOUT))
          state_d = S_DONE;
        else if (ofifo_valid && cnt_q == CW'(len_q) - CW'(1))
          state_d = S_DONE;
        else if (TimeoutEn && !ofifo_valid && idle_q == TW'(TIMEOUT - 1))
          err_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d  = '0;
      idle_d = '0;
    end

    inst_d = IDLE_WORD;
    case (state_d)
      S_WL0: begin
        inst_d[35] = 1'b1;
        inst_d[34] = 1'b1;
        if (cnt_d < CW'(col)) begin
          inst_d[32]    = 1'b0;
          inst_d[30:20] = wb_d + cnt_d[10:0];
        end
        // l0_wr trails the pmem read by the one-cycle SRAM latency.
        if (cnt_d != '0) inst_d[2] = 1'b1;
      end
      S_WLOAD: begin
        inst_d[35] = 1'b1;
        inst_d[3]  = 1'b1;
        inst_d[0]  = 1'b1;
      end
      S_AL0: begin
        inst_d[35] = 1'b1;
        if (cnt_d < CW'(len_d)) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = ab_d + cnt_d[10:0];
        end
        if (cnt_d != '0) inst_d[2] = 1'b1;
      end
      S_EXEC: begin
        inst_d[35] = 1'b1;
        inst_d[33] = acc_en;
        inst_d[3]  = 1'b1;
        inst_d[1]  = 1'b1;
      end
      S_WDRAIN, S_XDRAIN: inst_d[35] = 1'b1;
      default: inst_d = IDLE_WORD;
    endcase
  end

  // State and registered outputs; reset anywhere aborts the tile silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      wb_q    <= '0;
      ab_q    <= '0;
      len_q   <= '0;
      inst_q  <= IDLE_WORD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      wb_q    <= wb_d;
      ab_q    <= ab_d;
      len_q   <= len_d;
      inst_q  <= inst_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      err_q   <= err_d;
    end
  end

  // ofifo_rd must react to ofifo_valid in the same cycle, so it bypasses the register.
  assign inst = inst_q | {29'd0, (state_q == S_OUT) & ofifo_valid, 6'd0};
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
